// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller wrapped around an external 4-bit combinational ALU.
// Each instruction is accepted, then executed, then written back (IDLE -> EXEC -> WB).
module alu_issue_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [1:0]       instr_rd,
    input  logic [1:0]       instr_rs1,
    input  logic [1:0]       instr_rs2,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [3:0]       ld_data,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [3:0]       alu_result,
    input  logic             alu_zero,
    output logic             wb_valid,
    output logic [1:0]       wb_rd,
    output logic [3:0]       wb_data,
    output logic             zero_flag,
    output logic [CNT_W-1:0] retired,
    input  logic [1:0]       dbg_addr,
    output logic [3:0]       dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_regs [4];
    logic [1:0] r_rd;
    logic       r_zf;
    logic       w_accept;

    assign instr_ready = (r_state == IDLE);
    assign w_accept    = instr_valid && instr_ready;
    assign dbg_data    = r_regs[dbg_addr];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            r_rd       <= '0;
            r_zf       <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            zero_flag  <= 1'b0;
            retired    <= '0;
        end else begin
            if (w_accept) begin
                alu_a      <= r_regs[instr_rs1];
                alu_b      <= r_regs[instr_rs2];
                alu_opcode <= instr_op;
                r_rd       <= instr_rd;
            end
            if (r_state == EXEC) begin
                wb_data  <= alu_result;
                r_zf     <= alu_zero;
                wb_rd    <= r_rd;
                wb_valid <= 1'b1;
            end
            if (r_state == WB) begin
                wb_valid  <= 1'b0;
                zero_flag <= r_zf;
                retired   <= retired + 1'b1;
            end
        end
    end

    // A writeback to the same index as a direct load takes priority over the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_state == WB && wb_rd == 2'(i)) begin
                    r_regs[i] <= wb_data;
                end else if (ld_en && ld_addr == 2'(i)) begin
                    r_regs[i] <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the controller.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;
    logic       zero_flag;
    logic [7:0] retired;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int tests = 0;
    int fails = 0;

    alu_issue_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_op   (instr_op),
        .instr_rd   (instr_rd),
        .instr_rs1  (instr_rs1),
        .instr_rs2  (instr_rs2),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .zero_flag  (zero_flag),
        .retired    (retired),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // The external ALU the controller drives.
    assign alu_result = aluRef(alu_a, alu_b, alu_opcode);
    assign alu_zero   = (alu_result == 4'd0);

    // Transaction-level model: mAge counts edges since the last accept
    // (2 or more means the controller is free to take a new instruction).
    logic [3:0] mRegs [4];
    logic [3:0] mA, mB, mWbData;
    logic [1:0] mOp, mRd, mWbRd;
    logic       mZf, mAcc;
    logic [7:0] mRetired;
    int         mAge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mRegs[i] = 4'd0;
            mA = 0; mB = 0; mOp = 0; mRd = 0;
            mWbRd = 0; mWbData = 0; mZf = 0; mRetired = 0;
            mAge = 2;
        end else begin
            mAcc = instr_valid && (mAge >= 2);
            if (mAge == 0) begin
                mWbRd   = mRd;
                mWbData = aluRef(mA, mB, mOp);
            end
            if (mAcc) begin
                mA  = mRegs[instr_rs1];
                mB  = mRegs[instr_rs2];
                mOp = instr_op;
                mRd = instr_rd;
            end
            if (ld_en) mRegs[ld_addr] = ld_data;
            if (mAge == 1) begin
                mRegs[mWbRd] = mWbData;
                mZf          = (mWbData == 4'd0);
                mRetired     = mRetired + 8'd1;
            end
            mAge = mAcc ? 0 : ((mAge < 2) ? mAge + 1 : 2);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("ready", int'(instr_ready), int'(mAge >= 2));
        checkOutput("alu_a", int'(alu_a), int'(mA));
        checkOutput("alu_b", int'(alu_b), int'(mB));
        checkOutput("alu_op", int'(alu_opcode), int'(mOp));
        checkOutput("wb_valid", int'(wb_valid), int'(mAge == 1));
        checkOutput("wb_rd", int'(wb_rd), int'(mWbRd));
        checkOutput("wb_data", int'(wb_data), int'(mWbData));
        checkOutput("zero_flag", int'(zero_flag), int'(mZf));
        checkOutput("retired", int'(retired), int'(mRetired));
        checkOutput("dbg_data", int'(dbg_data), int'(mRegs[dbg_addr]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [1:0] rd,
                                 input logic [1:0] rs1, input logic [1:0] rs2,
                                 input logic le, input logic [1:0] la, input logic [3:0] ldv);
        instr_valid = v;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        ld_en       = le;
        ld_addr     = la;
        ld_data     = ldv;
    endtask

    task automatic loadReg(input logic [1:0] addr, input logic [3:0] data);
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, addr, data);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic runInstr(input string name, input logic [1:0] op, input logic [1:0] rd,
                            input logic [1:0] rs1, input logic [1:0] rs2,
                            input int expA, input int expB, input int expData, input int expZf);
        applyStimulus(1'b1, op, rd, rs1, rs2, 1'b0, 2'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        checkOutput({name, "_a"}, int'(alu_a), expA);
        checkOutput({name, "_b"}, int'(alu_b), expB);
        checkOutput({name, "_op"}, int'(alu_opcode), int'(op));
        tick();
        checkOutput({name, "_wbv"}, int'(wb_valid), 1);
        checkOutput({name, "_wbrd"}, int'(wb_rd), int'(rd));
        checkOutput({name, "_wbdata"}, int'(wb_data), expData);
        tick();
        checkOutput({name, "_zf"}, int'(zero_flag), expZf);
        dbg_addr = rd;
        #1;
        checkOutput({name, "_dbg"}, int'(dbg_data), expData);
    endtask

    initial begin
        int pulses;
        int busy;
        rst_n    = 1'b1;
        dbg_addr = 2'd0;
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_ready", int'(instr_ready), 1);
        checkOutput("reset_retired", int'(retired), 0);
        checkOutput("reset_wbv", int'(wb_valid), 0);
        doReset();

        loadReg(2'd0, 4'd5);
        loadReg(2'd1, 4'd3);
        runInstr("add", 2'b00, 2'd2, 2'd0, 2'd1, 5, 3, 8, 0);
        checkOutput("add_retired", int'(retired), 1);
        runInstr("sub_zero", 2'b01, 2'd3, 2'd0, 2'd0, 5, 5, 0, 1);
        loadReg(2'd0, 4'd2);
        loadReg(2'd1, 4'd8);
        runInstr("sub_wrap", 2'b01, 2'd3, 2'd0, 2'd1, 2, 8, 10, 0);
        loadReg(2'd0, 4'd15);
        loadReg(2'd1, 4'd1);
        runInstr("add_wrap", 2'b00, 2'd0, 2'd0, 2'd1, 15, 1, 0, 1);
        loadReg(2'd0, 4'd12);
        loadReg(2'd1, 4'd3);
        runInstr("and", 2'b10, 2'd2, 2'd0, 2'd1, 12, 3, 0, 1);
        loadReg(2'd0, 4'd10);
        loadReg(2'd1, 4'd5);
        runInstr("or", 2'b11, 2'd2, 2'd0, 2'd1, 10, 5, 15, 0);
        checkOutput("six_retired", int'(retired), 6);

        // Held request: valid stays high for six edges.
        doReset();
        loadReg(2'd0, 4'd1);
        loadReg(2'd1, 4'd2);
        pulses = 0;
        busy   = 0;
        applyStimulus(1'b1, 2'b00, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wb_valid) pulses++;
            if (!instr_ready) busy++;
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        checkOutput("hold_pulses", pulses, 2);
        checkOutput("hold_busy", busy, 4);
        checkOutput("hold_retired", int'(retired), 2);

        // Load to the destination in the writeback cycle: writeback wins.
        applyStimulus(1'b1, 2'b00, 2'd1, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 4'd7);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        dbg_addr = 2'd1;
        #1;
        checkOutput("wb_beats_ld", int'(dbg_data), 3);

        // Load to rs1 on the accept edge: operand sees the old value.
        applyStimulus(1'b1, 2'b00, 2'd2, 2'd0, 2'd1, 1'b1, 2'd0, 4'd9);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        checkOutput("acc_old_a", int'(alu_a), 1);
        dbg_addr = 2'd0;
        #1;
        checkOutput("acc_new_r0", int'(dbg_data), 9);
        tick();
        tick();

        // Reset during EXEC drops the pending writeback.
        applyStimulus(1'b1, 2'b00, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_a", int'(alu_a), 0);
        checkOutput("rst_b", int'(alu_b), 0);
        checkOutput("rst_wbdata", int'(wb_data), 0);
        checkOutput("rst_retired", int'(retired), 0);
        checkOutput("rst_r0", int'(dbg_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rst_ready", int'(instr_ready), 1);
        checkOutput("rst_nowb", int'(wb_valid), 0);
        checkOutput("rst_retired2", int'(retired), 0);

        // Random traffic long enough to wrap the retired counter.
        for (int i = 0; i < 2500; i++) begin
            applyStimulus(($urandom_range(9) < 7), 2'($urandom), 2'($urandom), 2'($urandom),
                          2'($urandom), ($urandom_range(3) == 0), 2'($urandom), 4'($urandom));
            dbg_addr = 2'($urandom);
            tick();
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
